w_mem_row_loader: RTL and testbench
===================================

# w_mem_row_loader

Upstream write sequencer for the weight SRAM wrapper. It accepts a valid/ready stream of packed weight words from the DMA/streamer and assembles them into full SRAM rows of `ROW_WEIGHTS` signed weights. It issues one-cycle row writes on the wrapper's CNN or FC write port with auto-incrementing addresses. A configuration handshake starts a transfer, and a one-cycle `done` pulse ends it.

## Interface
Parameters:
- `WEIGHT_DATA_WIDTH`, default 8: bits per weight.
- `IN_WIDTH`, default 32: stream word width. Must be a multiple of `WEIGHT_DATA_WIDTH`.
- `ROW_WEIGHTS`, default 8: weights per SRAM row (= `SUBBLOCK_W_MEM_SRAM_blocks_per_row`). Must be a multiple of `IN_WIDTH/WEIGHT_DATA_WIDTH`.
- `CNN_ADDR_W`, default 12: CNN write address width.
- `FC_ADDR_W`, default 14: FC write address width.
- `CNT_W`, default 16: word-count width.

Ports:
- `clk`, in, 1: clock. All state is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cfg_start`, in, 1: pulse that starts a transfer. Honoured only in IDLE.
- `cfg_fc`, in, 1: target port select. 0 = CNN port, 1 = FC port.
- `cfg_base_addr`, in, `FC_ADDR_W`: first row address. Truncated to `CNN_ADDR_W` for CNN.
- `cfg_num_words`, in, `CNT_W`: total stream words in the transfer.
- `cfg_abort`, in, 1: synchronous abort.
- `in_data`, in, `IN_WIDTH`: packed weights. Weight 0 sits in the LSBs.
- `in_valid`, in, 1; `in_ready`, out, 1: stream handshake.
- `wr_enable_cnn`, out, 1; `wr_addr_cnn`, out, `CNN_ADDR_W`; `wr_data_cnn`, out, `ROW_WEIGHTS`×`WEIGHT_DATA_WIDTH` (unpacked array): CNN write port.
- `wr_enable_fc`, out, 1; `wr_addr_fc`, out, `FC_ADDR_W`; `wr_data_fc`, out, `ROW_WEIGHTS`×`WEIGHT_DATA_WIDTH` (unpacked array): FC write port.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at the end of a transfer.
- `err_partial`, out, 1: sticky flag. Cleared on `cfg_start`.

## Operation
- Derived constants:
  - `WPW = IN_WIDTH/WEIGHT_DATA_WIDTH`.
  - `WPR = ROW_WEIGHTS/WPW` (words per row).
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE:** On `cfg_start`, latch `cfg_fc`, `cfg_base_addr` and `cfg_num_words`; clear the word counter, row buffer and `err_partial`.
  - If `cfg_num_words==0`, go to DONE.
  - Otherwise go to FILL.
- **FILL:** `in_ready=1`. Each accepted word (`in_valid && in_ready`) goes into row-buffer slots `[k*WPW +: WPW]`, where `k` is the word index within the row.
  - Go to WRITE when `k==WPR-1` or when the total word count reaches `cfg_num_words`.
- **WRITE:** `in_ready=0`. The selected `wr_enable_*` is high for exactly one cycle. The address is base + row index, wrapping modulo 2^width. The data is the row buffer.
  - Then clear the buffer and increment the row index.
  - Go to DONE if all words have been consumed, otherwise back to FILL.
- **Partial last row** (`cfg_num_words` not a multiple of `WPR`): behaviour is set by the macro below.
- **DONE:** `done=1` for one cycle, then IDLE.
- **Abort:** `cfg_abort` in any state forces IDLE at the next edge. No write is issued from that edge onward, `done` is not pulsed, and the buffer is cleared. `cfg_abort` takes priority over `cfg_start` in the same cycle.
- The non-selected port's `wr_enable` is always 0. Both data/address buses hold 0 whenever their enable is 0.
- `cfg_start` while busy is ignored.

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the state register.
- Reset values: every output is 0, the FSM is in IDLE and the counters are 0.
- Word accepted at cycle t completes a row → write visible during cycle t+1.
- Throughput: `WPR` words per `WPR+1` cycles.
- `done` asserts the cycle after the final write. From `cfg_start` to first `in_ready` is 1 cycle.
- Reset mid-transfer: everything returns to reset values asynchronously. The partial row is lost.
- `in_valid` low in FILL: the block waits indefinitely with no timeout.

## Configuration
- `W_LOADER_ZERO_PAD_EN` defined: a partial final row has its unfilled slots zero-padded and is written normally. `err_partial` stays 0.
- `W_LOADER_ZERO_PAD_EN` undefined: a partial final row is discarded (no write) and `err_partial` is set. FILL goes directly to DONE.

## Test plan
- CNN full rows: `cfg_fc=0`, base 0x010, 4 words (defaults, `WPR=2`), data 0x03020100…0x0F0E0D0C → two CNN writes at 0x010/0x011 with weights 0..7 and 8..15, then `done` 1 cycle after the second write.
- FC port with address wrap: `cfg_fc=1`, base 0x3FFF, 4 words → writes at 0x3FFF then 0x0000, and `wr_enable_cnn` stays 0 throughout.
- Partial row: 3 words → with the macro, 2 writes and the second row's upper 4 weights are 0; without it, 1 write and `err_partial=1`.
- Backpressure/gaps: `in_valid` toggled 1,0,0,1 → a single write one cycle after the 2nd accepted word, and `in_ready` low during the WRITE cycle.
- Abort plus zero-length: `cfg_abort` after 1 word → no write, no `done`, `busy` falls next cycle. Then `cfg_num_words=0` → `done` 1 cycle after start, no writes.
- Async reset asserted in WRITE → `wr_enable_*` drops immediately. A new transfer after release behaves like the first scenario.

Source files
------------

// File: rtl/w_mem_row_loader.sv
// Packs a valid/ready stream of weight words into SRAM rows and issues one-cycle row writes
// on the CNN or FC port. Define W_LOADER_ZERO_PAD_EN to zero-pad and write a partial last row.
module w_mem_row_loader #(
    parameter int unsigned WEIGHT_DATA_WIDTH = 8,
    parameter int unsigned IN_WIDTH          = 32,
    parameter int unsigned ROW_WEIGHTS       = 8,
    parameter int unsigned CNN_ADDR_W        = 12,
    parameter int unsigned FC_ADDR_W         = 14,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_start,
    input  logic                         cfg_fc,
    input  logic [FC_ADDR_W-1:0]         cfg_base_addr,
    input  logic [CNT_W-1:0]             cfg_num_words,
    input  logic                         cfg_abort,
    input  logic [IN_WIDTH-1:0]          in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         wr_enable_cnn,
    output logic [CNN_ADDR_W-1:0]        wr_addr_cnn,
    output logic [WEIGHT_DATA_WIDTH-1:0] wr_data_cnn [ROW_WEIGHTS],
    output logic                         wr_enable_fc,
    output logic [FC_ADDR_W-1:0]         wr_addr_fc,
    output logic [WEIGHT_DATA_WIDTH-1:0] wr_data_fc [ROW_WEIGHTS],
    output logic                         busy,
    output logic                         done,
    output logic                         err_partial
);

    localparam int unsigned WPW = IN_WIDTH / WEIGHT_DATA_WIDTH;
    localparam int unsigned WPR = ROW_WEIGHTS / WPW;
    localparam int unsigned KW  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [KW-1:0] KLast = KW'(WPR - 1);

`ifdef W_LOADER_ZERO_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFill, StWrite, StDone} state_e;

    state_e                       state;
    logic                         fc_sel;
    logic [FC_ADDR_W-1:0]         base_addr;
    logic [CNT_W-1:0]             num_words;
    logic [CNT_W-1:0]             word_cnt;
    logic [KW-1:0]                k;
    logic [FC_ADDR_W-1:0]         row_idx;
    logic [WEIGHT_DATA_WIDTH-1:0] row_buf  [ROW_WEIGHTS];
    logic [WEIGHT_DATA_WIDTH-1:0] row_next [ROW_WEIGHTS];

    logic                 accept;
    logic                 last_word;
    logic                 row_full;
    logic                 do_write;
    logic                 do_discard;
    logic [FC_ADDR_W-1:0] wr_addr_full;

    assign in_ready     = (state == StFill);
    assign accept       = in_ready && in_valid;
    assign last_word    = (word_cnt + CNT_W'(1)) == num_words;
    assign row_full     = (k == KLast);
    assign do_write     = accept && (row_full || (last_word && PadEn));
    assign do_discard   = accept && last_word && !row_full && !PadEn;
    assign wr_addr_full = base_addr + row_idx;

    // Row buffer with the incoming word merged into slot group k.
    always_comb begin
        for (int s = 0; s < ROW_WEIGHTS; s++) begin
            row_next[s] = row_buf[s];
            if (KW'(s / WPW) == k) begin
                row_next[s] = in_data[(s % WPW) * WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            fc_sel        <= 1'b0;
            base_addr     <= '0;
            num_words     <= '0;
            word_cnt      <= '0;
            k             <= '0;
            row_idx       <= '0;
            row_buf       <= '{default: '0};
            wr_enable_cnn <= 1'b0;
            wr_addr_cnn   <= '0;
            wr_data_cnn   <= '{default: '0};
            wr_enable_fc  <= 1'b0;
            wr_addr_fc    <= '0;
            wr_data_fc    <= '{default: '0};
            busy          <= 1'b0;
            done          <= 1'b0;
            err_partial   <= 1'b0;
        end else begin
            // Write ports and done are single-cycle: idle unless set below.
            wr_enable_cnn <= 1'b0;
            wr_addr_cnn   <= '0;
            wr_data_cnn   <= '{default: '0};
            wr_enable_fc  <= 1'b0;
            wr_addr_fc    <= '0;
            wr_data_fc    <= '{default: '0};
            done          <= 1'b0;

            if (cfg_abort) begin
                state    <= StIdle;
                busy     <= 1'b0;
                word_cnt <= '0;
                k        <= '0;
                row_idx  <= '0;
                row_buf  <= '{default: '0};
            end else begin
                unique case (state)
                    StIdle: begin
                        if (cfg_start) begin
                            fc_sel      <= cfg_fc;
                            base_addr   <= cfg_base_addr;
                            num_words   <= cfg_num_words;
                            word_cnt    <= '0;
                            k           <= '0;
                            row_idx     <= '0;
                            row_buf     <= '{default: '0};
                            err_partial <= 1'b0;
                            busy        <= 1'b1;
                            if (cfg_num_words == '0) begin
                                state <= StDone;
                                done  <= 1'b1;
                            end else begin
                                state <= StFill;
                            end
                        end
                    end
                    StFill: begin
                        if (accept) begin
                            word_cnt <= word_cnt + CNT_W'(1);
                            if (row_full || last_word) begin
                                k       <= '0;
                                row_buf <= '{default: '0};
                            end else begin
                                k       <= k + KW'(1);
                                row_buf <= row_next;
                            end
                        end
                        if (do_write) begin
                            state <= StWrite;
                            if (fc_sel) begin
                                wr_enable_fc <= 1'b1;
                                wr_addr_fc   <= wr_addr_full;
                                wr_data_fc   <= row_next;
                            end else begin
                                wr_enable_cnn <= 1'b1;
                                wr_addr_cnn   <= wr_addr_full[CNN_ADDR_W-1:0];
                                wr_data_cnn   <= row_next;
                            end
                        end else if (do_discard) begin
                            state       <= StDone;
                            done        <= 1'b1;
                            err_partial <= 1'b1;
                        end
                    end
                    StWrite: begin
                        row_idx <= row_idx + FC_ADDR_W'(1);
                        if (word_cnt == num_words) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StFill;
                        end
                    end
                    StDone: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_w_mem_row_loader.sv
// Randomized bench for w_mem_row_loader; expected rows come from a byte-stream model of the transfer.
module tb_w_mem_row_loader;

    localparam int W   = 8;
    localparam int IW  = 32;
    localparam int RW  = 8;
    localparam int CA  = 12;
    localparam int FA  = 14;
    localparam int CW  = 16;
    localparam int WPW = IW / W;
    localparam int WPR = RW / WPW;

`ifdef W_LOADER_ZERO_PAD_EN
    localparam bit Pad = 1'b1;
`else
    localparam bit Pad = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_fc = 1'b0;
    logic [FA-1:0] cfg_base_addr = '0;
    logic [CW-1:0] cfg_num_words = '0;
    logic          cfg_abort = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          wr_enable_cnn;
    logic [CA-1:0] wr_addr_cnn;
    logic [W-1:0]  wr_data_cnn [RW];
    logic          wr_enable_fc;
    logic [FA-1:0] wr_addr_fc;
    logic [W-1:0]  wr_data_fc [RW];
    logic          busy;
    logic          done;
    logic          err_partial;

    w_mem_row_loader dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_fc        (cfg_fc),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_words (cfg_num_words),
        .cfg_abort     (cfg_abort),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wr_enable_cnn (wr_enable_cnn),
        .wr_addr_cnn   (wr_addr_cnn),
        .wr_data_cnn   (wr_data_cnn),
        .wr_enable_fc  (wr_enable_fc),
        .wr_addr_fc    (wr_addr_fc),
        .wr_data_fc    (wr_data_fc),
        .busy          (busy),
        .done          (done),
        .err_partial   (err_partial)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [IW-1:0] words[$];
    bit            pat[$];
    logic [FA-1:0] exp_addr[$];
    logic [63:0]   exp_data[$];
    logic [FA-1:0] got_addr[$];
    logic [63:0]   got_data[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] row_bits(input bit fc);
        logic [63:0] r;
        r = '0;
        for (int s = 0; s < RW; s++) r[s*W +: W] = fc ? wr_data_fc[s] : wr_data_cnn[s];
        return r;
    endfunction

    // Transfer viewed as a flat weight stream cut into rows of RW weights.
    task automatic build_model(input bit fc, input logic [FA-1:0] base, input int n,
                               output bit exp_err);
        int nrows;
        int nweights;
        logic [63:0] d;
        logic [FA-1:0] a;
        exp_addr.delete();
        exp_data.delete();
        nweights = n * WPW;
        nrows    = Pad ? (n + WPR - 1) / WPR : n / WPR;
        exp_err  = !Pad && (n % WPR != 0);
        for (int r = 0; r < nrows; r++) begin
            d = '0;
            for (int s = 0; s < RW; s++) begin
                int wi;
                wi = r * RW + s;
                if (wi < nweights) d[s*W +: W] = words[wi / WPW][(wi % WPW) * W +: W];
            end
            a = base + FA'(r);
            if (!fc) a = a & FA'(12'hFFF);
            exp_addr.push_back(a);
            exp_data.push_back(d);
        end
    endtask

    task automatic run_xfer(input bit fc, input logic [FA-1:0] base, input int n,
                            input int gap_pct);
        bit exp_err, exp_wr, exp_done, seen_done, first, wr, completes;
        int sent, cyc;
        build_model(fc, base, n, exp_err);
        got_addr.delete();
        got_data.delete();
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_fc = fc; cfg_base_addr = base; cfg_num_words = CW'(n);
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_fc = 1'($urandom); cfg_base_addr = FA'($urandom);
        cfg_num_words = CW'($urandom);
        exp_wr = 1'b0; exp_done = (n == 0); seen_done = 1'b0; sent = 0; cyc = 0; first = 1'b1;
        while (!seen_done && cyc < 500) begin
            if (pat.size() != 0) in_valid = (sent < n) && pat[cyc % pat.size()];
            else in_valid = (sent < n) && (int'($urandom_range(99)) >= gap_pct);
            in_data = (sent < n) ? words[sent] : IW'($urandom);
            @(negedge clk);
            wr = fc ? wr_enable_fc : wr_enable_cnn;
            if (first && n > 0) check_eq("ready_after_start", in_ready, 1);
            first = 1'b0;
            check_eq("wr_timing", wr, exp_wr);
            check_eq("done_timing", done, exp_done);
            check_eq("other_port_en", fc ? wr_enable_cnn : wr_enable_fc, 0);
            check_eq("busy_in_xfer", busy, 1);
            if (!wr_enable_cnn) check_eq("cnn_bus_idle", {wr_addr_cnn, row_bits(1'b0)}, 0);
            if (!wr_enable_fc) check_eq("fc_bus_idle", {wr_addr_fc, row_bits(1'b1)}, 0);
            if (wr) begin
                check_eq("ready_low_in_write", in_ready, 0);
                got_addr.push_back(fc ? wr_addr_fc : FA'(wr_addr_cnn));
                got_data.push_back(row_bits(fc));
            end
            if (done) seen_done = 1'b1;
            exp_wr   = 1'b0;
            exp_done = wr && (sent == n);
            if (in_valid && in_ready) begin
                completes = ((sent + 1) % WPR == 0) || (Pad && sent + 1 == n);
                exp_wr = completes;
                if (sent + 1 == n && !completes) exp_done = 1'b1;
                sent++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("done_seen", seen_done, 1);
        check_eq("done_one_cycle", done, 0);
        check_eq("busy_after_done", busy, 0);
        check_eq("err_partial", err_partial, exp_err);
        check_eq("nwrites", got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            check_eq("wr_addr", got_addr[i], exp_addr[i]);
            check_eq("wr_data", got_data[i], exp_data[i]);
        end
    endtask

    task automatic run_first_scenario();
        words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        pat.delete();
        run_xfer(1'b0, 14'h010, 4, 0);
        if (got_addr.size() >= 2) begin
            check_eq("s1_addr0", got_addr[0], 14'h010);
            check_eq("s1_addr1", got_addr[1], 14'h011);
            check_eq("s1_data0", got_data[0], 64'h0706050403020100);
            check_eq("s1_data1", got_data[1], 64'h0F0E0D0C0B0A0908);
        end else begin
            check_eq("s1_write_count", got_addr.size(), 2);
        end
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(IW'($urandom));
    endtask

    initial begin
        bit found;
        #2;
        check_eq("rst_outputs", {in_ready, wr_enable_cnn, wr_addr_cnn, wr_enable_fc, wr_addr_fc,
                                 busy, done, err_partial}, 0);
        check_eq("rst_data", {row_bits(1'b0), row_bits(1'b1)}, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_first_scenario();

        // FC port with address wrap.
        fill_words(4);
        run_xfer(1'b1, 14'h3FFF, 4, 0);
        if (got_addr.size() >= 2) begin
            check_eq("fc_wrap_addr0", got_addr[0], 14'h3FFF);
            check_eq("fc_wrap_addr1", got_addr[1], 14'h0000);
        end

        // Partial last row.
        fill_words(3);
        run_xfer(1'b0, 14'h100, 3, 0);
        check_eq("partial_nwrites", got_addr.size(), Pad ? 2 : 1);
        if (Pad && got_addr.size() >= 2) check_eq("partial_upper_zero", got_data[1][63:32], 0);

        // Backpressure: valid 1,0,0,1.
        fill_words(2);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_xfer(1'b0, 14'h040, 2, 0);
        pat.delete();

        // Abort after one word.
        fill_words(4);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_fc = 1'b0; cfg_base_addr = 14'h200; cfg_num_words = 16'd4;
        @(posedge clk); #1;
        cfg_start = 1'b0; in_valid = 1'b1; in_data = words[0];
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_abort = 1'b1;
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        @(negedge clk);
        check_eq("abort_busy_low", busy, 0);
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = words[1];
            @(negedge clk);
            if (wr_enable_cnn || wr_enable_fc || done || in_ready) found = 1'b1;
        end
        in_valid = 1'b0;
        check_eq("abort_quiet", found, 0);

        // Abort wins over start in the same cycle.
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_abort = 1'b1; cfg_num_words = 16'd4;
        @(posedge clk); #1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        @(negedge clk);
        check_eq("abort_over_start", {busy, in_ready}, 0);

        // Zero-length transfer.
        words.delete();
        run_xfer(1'b1, 14'h0123, 0, 0);

        // Async reset while writing.
        fill_words(4);
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_fc = 1'b0; cfg_base_addr = 14'h020; cfg_num_words = 16'd4;
        @(posedge clk); #1;
        cfg_start = 1'b0; in_valid = 1'b1; in_data = words[0];
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (wr_enable_cnn) found = 1'b1;
        end
        check_eq("rst_reached_write", found, 1);
        reset = 1'b0;
        #1;
        check_eq("rst_mid_outputs", {wr_enable_cnn, wr_addr_cnn, busy, done, in_ready}, 0);
        check_eq("rst_mid_data", row_bits(1'b0), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_first_scenario();

        // Randomized transfers.
        for (int t = 0; t < 25; t++) begin
            int n;
            bit fc;
            logic [FA-1:0] base;
            n    = int'($urandom_range(9));
            fc   = 1'($urandom_range(1));
            base = ($urandom_range(3) == 0) ? 14'h3FFF : FA'($urandom);
            fill_words(n);
            run_xfer(fc, base, n, int'($urandom_range(60)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
